// File: rtl/pwm_output_stage_if.sv
// Configuration bundle from the SPI register block: output enables, PWM selects and shared duty.
interface pwm_output_stage_if;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle
    );

    modport slave (
        input en_reg_out_7_0,
        input en_reg_out_15_8,
        input en_reg_pwm_7_0,
        input en_reg_pwm_15_8,
        input pwm_duty_cycle
    );
endinterface

// File: rtl/pwm_output_stage.sv
// 16-bit output stage: prescaled 8-bit PWM with a period-aligned duty shadow and
// registered per-bit enable / PWM-select muxing.
module pwm_output_stage #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pwm_output_stage_if.slave        cfg,
    output logic              [15:0] out_o,
    output logic                     period_start_o
);

    localparam int unsigned    PsW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

    logic [PsW-1:0] ps_q, ps_d;
    logic [7:0]     pwm_cnt_q, pwm_cnt_d;
    logic [7:0]     duty_sh_q, duty_sh_d;
    logic [15:0]    out_q, out_d;
    logic           period_start_q, period_start_d;

    logic        tick;
    logic        wrap;
    logic        pwm;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    assign en_out = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
    assign en_pwm = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};

    always_comb begin
        tick      = (ps_q == PsMax);
        wrap      = tick && (pwm_cnt_q == 8'hFF);
        ps_d      = tick ? '0 : ps_q + PsW'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        // Shadow only moves on the wrap edge so a period never sees a mid-period duty change.
        duty_sh_d = wrap ? cfg.pwm_duty_cycle : duty_sh_q;
        // 0xFF is full-on; the compare alone would drop the last count of each period.
        pwm            = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);
        out_d          = en_out & (~en_pwm | {16{pwm}});
        period_start_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q           <= '0;
            pwm_cnt_q      <= '0;
            duty_sh_q      <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            ps_q           <= ps_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_sh_q      <= duty_sh_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out_o          = out_q;
    assign period_start_o = period_start_q;

endmodule
